// File: rtl/ffe_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ffe_tap_sequencer
// Description : Maps channel corner-frequency estimates to FFE pre/post tap
//               targets and ramps the TX driver taps toward them one LSB per
//               step over a valid/ready handshake, pausing STEP_INTERVAL
//               clocks between steps. The main tap always carries the
//               remaining weight: MAIN_MAX - pre - post.
//               Optional: define FFE_HYSTERESIS_EN to ignore new codes whose
//               post-tap target lies within HYST LSBs of the current one.
// Revision    : 1.0 - initial release
// ============================================================================
module ffe_tap_sequencer #(
    parameter int unsigned FREQ_WIDTH    = 12,
    parameter int unsigned TAP_WIDTH     = 6,
    parameter int unsigned STEP_INTERVAL = 16,
    parameter int unsigned HYST          = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FREQ_WIDTH-1:0] freq_code,
    input  logic                  freq_valid,
    output logic [TAP_WIDTH-1:0]  pre_tap,
    output logic [TAP_WIDTH-1:0]  main_tap,
    output logic [TAP_WIDTH-1:0]  post_tap,
    output logic                  tap_valid,
    input  logic                  tap_ready,
    output logic                  settled,
    output logic                  busy
);

`ifdef FFE_HYSTERESIS_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    localparam int unsigned          SHIFT    = FREQ_WIDTH - TAP_WIDTH + 1;
    localparam int unsigned          CNT_W    = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STEP_INTERVAL - 1);
    localparam logic [TAP_WIDTH-1:0] MAIN_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MAP       = 3'd1,
        S_STEP      = 3'd2,
        S_HANDSHAKE = 3'd3,
        S_WAIT      = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic [FREQ_WIDTH-1:0] code_q,      code_d;
    logic [FREQ_WIDTH-1:0] pend_code_q, pend_code_d;
    logic                  pend_q,      pend_d;
    logic [TAP_WIDTH-1:0]  pre_q,       pre_d;
    logic [TAP_WIDTH-1:0]  post_q,      post_d;
    logic [TAP_WIDTH-1:0]  tgt_pre_q,   tgt_pre_d;
    logic [TAP_WIDTH-1:0]  tgt_post_q,  tgt_post_d;
    logic                  valid_q,     valid_d;
    logic                  settled_q,   settled_d;
    logic                  have_tgt_q,  have_tgt_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;

    // Targets derived from the latched code: a narrower channel (smaller
    // code) asks for more post-cursor emphasis.
    logic [TAP_WIDTH-1:0] map_post;
    logic [TAP_WIDTH-1:0] map_pre;
    logic [TAP_WIDTH-1:0] post_diff;
    logic                 at_target;
    logic                 map_at_target;
    logic                 hyst_reject;

    assign map_post      = TAP_WIDTH'((~code_q) >> SHIFT);
    assign map_pre       = map_post >> 2;
    assign post_diff     = (map_post > tgt_post_q) ? (map_post - tgt_post_q)
                                                   : (tgt_post_q - map_post);
    assign at_target     = (pre_q == tgt_pre_q) && (post_q == tgt_post_q);
    assign map_at_target = (pre_q == map_pre) && (post_q == map_post);
    // The first code after reset has no previous target to compare with.
    assign hyst_reject   = HYST_EN && have_tgt_q && (32'(post_diff) <= HYST);

    // Next-state and datapath decisions for the ramp sequencer.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        pre_d       = pre_q;
        post_d      = post_q;
        tgt_pre_d   = tgt_pre_q;
        tgt_post_d  = tgt_post_q;
        valid_d     = valid_q;
        settled_d   = 1'b0;
        have_tgt_d  = have_tgt_q;
        cnt_d       = cnt_q;

        // Codes arriving while busy park in a one-deep slot; newest wins.
        if (freq_valid && (state_q != S_IDLE)) begin
            pend_d      = 1'b1;
            pend_code_d = freq_code;
        end

        case (state_q)
            S_IDLE: begin
                if (freq_valid) begin
                    code_d  = freq_code;
                    state_d = S_MAP;
                end else if (pend_q) begin
                    code_d  = pend_code_q;
                    pend_d  = 1'b0;
                    state_d = S_MAP;
                end
            end
            S_MAP: begin
                if (hyst_reject) begin
                    // Keep the old targets; resume only if still short of them.
                    state_d = at_target ? S_IDLE : S_STEP;
                end else begin
                    tgt_pre_d  = map_pre;
                    tgt_post_d = map_post;
                    have_tgt_d = 1'b1;
                    if (map_at_target) begin
                        settled_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                if (pre_q < tgt_pre_q) begin
                    pre_d = pre_q + TAP_WIDTH'(1);
                end else if (pre_q > tgt_pre_q) begin
                    pre_d = pre_q - TAP_WIDTH'(1);
                end
                if (post_q < tgt_post_q) begin
                    post_d = post_q + TAP_WIDTH'(1);
                end else if (post_q > tgt_post_q) begin
                    post_d = post_q - TAP_WIDTH'(1);
                end
                valid_d = 1'b1;
                state_d = S_HANDSHAKE;
            end
            S_HANDSHAKE: begin
                if (tap_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (freq_valid || pend_q) begin
                        code_d  = freq_valid ? freq_code : pend_code_q;
                        pend_d  = 1'b0;
                        state_d = S_MAP;
                    end else if (at_target) begin
                        settled_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_STEP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any ramp or handshake.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            pend_q      <= 1'b0;
            pend_code_q <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            tgt_pre_q   <= '0;
            tgt_post_q  <= '0;
            valid_q     <= 1'b0;
            settled_q   <= 1'b0;
            have_tgt_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            tgt_pre_q   <= tgt_pre_d;
            tgt_post_q  <= tgt_post_d;
            valid_q     <= valid_d;
            settled_q   <= settled_d;
            have_tgt_q  <= have_tgt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pre_tap   = pre_q;
    assign post_tap  = post_q;
    assign main_tap  = MAIN_MAX - pre_q - post_q;
    assign tap_valid = valid_q;
    assign settled   = settled_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
